// File: rtl/frame_sequencer.sv
// Frame sequencer: drives the pixel sampler through pixel reset, integration, readout and gap per frame.
// Optional readout watchdog is built when FRAME_SEQ_TIMEOUT_EN is defined.
module frame_sequencer #(
    parameter int PIXEL_NUM_ROW  = 7,
    parameter int PIXEL_NUM_COL  = 16,
    parameter int INTEG_W        = 16,
    parameter int GAP_W          = 8,
    parameter int FRAME_CNT_W    = 8,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_req,
    input  logic                   abort,
    input  logic [INTEG_W-1:0]     cfg_integ_cycles,
    input  logic [GAP_W-1:0]       cfg_gap_cycles,
    input  logic [FRAME_CNT_W-1:0] cfg_num_frames,
    input  logic                   cfg_cds,
    input  logic                   cfg_single,
    input  logic [7:0]             cfg_row_addr,
    input  logic [7:0]             cfg_col_addr,
    input  logic                   sampler_start,
    output logic                   smp_enable,
    output logic                   smp_pixel_disable,
    output logic                   smp_cds,
    output logic                   smp_single_en,
    output logic [7:0]             smp_row_addr,
    output logic [7:0]             smp_col_addr,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   seq_done,
    output logic [FRAME_CNT_W-1:0] frame_idx,
    output logic                   err_timeout
);

    // state     | meaning
    // IDLE      | waiting for start_req, sampler controls low
    // PIX_RST   | pixel_disable held for RST_CYCLES
    // INTEGRATE | all controls low for max(integ,1) cycles
    // READOUT   | sampler enabled until its start output falls
    // GAP       | controls low for max(gap,2) cycles, then next frame or done
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PIX_RST   = 3'd1;
    localparam logic [2:0] S_INTEGRATE = 3'd2;
    localparam logic [2:0] S_READOUT   = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    localparam int RST_W = $clog2(RST_CYCLES + 1);
    localparam int CNT_A = (INTEG_W > GAP_W) ? INTEG_W : GAP_W;
    localparam int CNT_W = (CNT_A > RST_W) ? CNT_A : RST_W;
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);

    if (RST_CYCLES < 1 || PIXEL_NUM_ROW < 1 || PIXEL_NUM_COL < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("frame_sequencer: invalid parameter value");
    end

    logic [2:0]             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0]       integ_load, gap_load;
    logic [INTEG_W-1:0]     integ_lat;
    logic [GAP_W-1:0]       gap_lat;
    logic [FRAME_CNT_W-1:0] nframes_lat;
    logic                   cds_lat, single_lat;
    logic [7:0]             row_lat, col_lat;
    logic                   ss_meta, ss_sync, seen_high;
    logic                   cnt_zero, last_frame, readout_end, tmo_hit;
    logic                   start_ok, frame_end, seq_end, frame_adv, active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_meta <= 1'b0;
            ss_sync <= 1'b0;
        end else begin
            ss_meta <= sampler_start;
            ss_sync <= ss_meta;
        end
    end

    always_comb begin
        integ_load = (integ_lat == '0) ? '0 : CNT_W'(integ_lat) - CNT_W'(1);
        // Gap floor of 2 lets the sampler's enable synchronizer clear its done flag.
        gap_load   = (gap_lat < GAP_W'(2)) ? CNT_W'(1) : CNT_W'(gap_lat) - CNT_W'(1);
        cnt_zero   = (cnt == '0);
        last_frame = (nframes_lat != '0) && (frame_idx == nframes_lat - FRAME_CNT_W'(1));
        readout_end = seen_high && !ss_sync;
        start_ok   = (state == S_IDLE) && start_req && !abort;
        frame_end  = (state == S_READOUT) && readout_end && !abort;
        seq_end    = (state == S_GAP) && cnt_zero && last_frame && !abort;
        frame_adv  = (state == S_GAP) && cnt_zero && !last_frame && !abort;
        active     = (state != S_IDLE) && !abort;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start_req) begin
                    state_nxt = S_PIX_RST;
                    cnt_nxt   = RST_LOAD;
                end
            end
            S_PIX_RST: begin
                if (cnt_zero) begin
                    state_nxt = S_INTEGRATE;
                    cnt_nxt   = integ_load;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_INTEGRATE: begin
                if (cnt_zero) begin
                    state_nxt = S_READOUT;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_READOUT: begin
                if (readout_end) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = gap_load;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_nxt = last_frame ? S_IDLE : S_PIX_RST;
                    cnt_nxt   = RST_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            cnt               <= '0;
            seen_high         <= 1'b0;
            frame_idx         <= '0;
            integ_lat         <= '0;
            gap_lat           <= '0;
            nframes_lat       <= '0;
            cds_lat           <= 1'b0;
            single_lat        <= 1'b0;
            row_lat           <= '0;
            col_lat           <= '0;
            smp_enable        <= 1'b0;
            smp_pixel_disable <= 1'b0;
            smp_cds           <= 1'b0;
            smp_single_en     <= 1'b0;
            smp_row_addr      <= '0;
            smp_col_addr      <= '0;
            busy              <= 1'b0;
            frame_done        <= 1'b0;
            seq_done          <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;

            if (start_ok) begin
                integ_lat   <= cfg_integ_cycles;
                gap_lat     <= cfg_gap_cycles;
                nframes_lat <= cfg_num_frames;
                cds_lat     <= cfg_cds;
                single_lat  <= cfg_single;
                row_lat     <= cfg_row_addr;
                col_lat     <= cfg_col_addr;
                frame_idx   <= '0;
            end else if (frame_adv) begin
                frame_idx <= frame_idx + FRAME_CNT_W'(1);
            end

            if (state != S_READOUT) begin
                seen_high <= 1'b0;
            end else if (ss_sync) begin
                seen_high <= 1'b1;
            end

            // Outputs follow the current state, so they lag a transition by one cycle.
            smp_enable        <= (state == S_READOUT) && !abort;
            smp_pixel_disable <= (state == S_PIX_RST) && !abort;
            busy              <= active;
            smp_cds           <= active && cds_lat;
            smp_single_en     <= active && single_lat;
            smp_row_addr      <= active ? row_lat : '0;
            smp_col_addr      <= active ? col_lat : '0;
            frame_done        <= frame_end;
            seq_done          <= seq_end;
        end
    end

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    assign tmo_hit     = (state == S_READOUT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_READOUT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (start_ok) begin
                err_q <= 1'b0;
            end else if (tmo_hit && !readout_end && !abort) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: sampler model plus a per-cycle monitor summarised into
// phase lengths and pulse timestamps, compared against durations derived from the frame rules.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_req = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_integ_cycles = '0;
    logic [7:0]  cfg_gap_cycles = '0;
    logic [7:0]  cfg_num_frames = '0;
    logic        cfg_cds = 1'b0;
    logic        cfg_single = 1'b0;
    logic [7:0]  cfg_row_addr = '0;
    logic [7:0]  cfg_col_addr = '0;
    logic        sampler_start = 1'b0;
    logic        smp_enable, smp_pixel_disable, smp_cds, smp_single_en;
    logic [7:0]  smp_row_addr, smp_col_addr;
    logic        busy, frame_done, seq_done, err_timeout;
    logic [7:0]  frame_idx;

    int n_checks = 0;
    int n_fail = 0;

    frame_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start_req(start_req), .abort(abort),
        .cfg_integ_cycles(cfg_integ_cycles), .cfg_gap_cycles(cfg_gap_cycles),
        .cfg_num_frames(cfg_num_frames), .cfg_cds(cfg_cds), .cfg_single(cfg_single),
        .cfg_row_addr(cfg_row_addr), .cfg_col_addr(cfg_col_addr), .sampler_start(sampler_start),
        .smp_enable(smp_enable), .smp_pixel_disable(smp_pixel_disable), .smp_cds(smp_cds),
        .smp_single_en(smp_single_en), .smp_row_addr(smp_row_addr), .smp_col_addr(smp_col_addr),
        .busy(busy), .frame_done(frame_done), .seq_done(seq_done), .frame_idx(frame_idx),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Sampler model: a few cycles after enable, raise start for sm_len negedges; sm_len 0 never raises.
    int sm_len = 10;
    int sm_cnt = 0;
    always @(negedge clk) begin
        if (!smp_enable) begin
            sm_cnt = 0;
            sampler_start = 1'b0;
        end else if (sm_len != 0 && sm_cnt <= sm_len + 2) begin
            sm_cnt++;
            if (sm_cnt == 3) sampler_start = 1'b1;
            if (sm_cnt == sm_len + 3) sampler_start = 1'b0;
        end
    end

    int cyc = 0;
    int pd_q[$], integ_q[$], gap_q[$], fd_q[$], fd_idx[$], sd_q[$];
    int pd_run, low_run, mode, gap_last, addr_err, idle_err;
    logic pd_prev = 1'b0, en_prev = 1'b0;
    logic       exp_cds, exp_single;
    logic [7:0] exp_row, exp_col;

    always @(negedge clk) begin
        cyc++;
        if (pd_prev && !smp_pixel_disable) begin
            pd_q.push_back(pd_run); pd_run = 0; mode = 1; low_run = 0;
        end
        if (en_prev && !smp_enable) begin
            mode = 2; low_run = 0;
        end
        if (!pd_prev && smp_pixel_disable && mode == 2) begin
            gap_q.push_back(low_run); mode = 0;
        end
        if (!en_prev && smp_enable && mode == 1) begin
            integ_q.push_back(low_run); mode = 0;
        end
        if (smp_pixel_disable) pd_run++;
        if (!smp_pixel_disable && !smp_enable && busy) low_run++;
        if (seq_done) begin sd_q.push_back(cyc); gap_last = low_run; end
        if (frame_done) begin fd_q.push_back(cyc); fd_idx.push_back(int'(frame_idx)); end
        if (busy && (smp_cds !== exp_cds || smp_single_en !== exp_single ||
                     smp_row_addr !== exp_row || smp_col_addr !== exp_col)) addr_err++;
        if (!busy && (smp_cds || smp_single_en || smp_row_addr != 0 || smp_col_addr != 0 ||
                      smp_enable || smp_pixel_disable)) idle_err++;
        pd_prev = smp_pixel_disable;
        en_prev = smp_enable;
    end

    task automatic clear_stats();
        pd_q.delete(); integ_q.delete(); gap_q.delete();
        fd_q.delete(); fd_idx.delete(); sd_q.delete();
        pd_run = 0; low_run = 0; mode = 0; gap_last = -1; addr_err = 0; idle_err = 0;
    endtask

    // Presents a configuration, pulses start_req, then scrambles cfg_* to show the latch holds.
    task automatic launch(input int n, input int ig, input int gp, input logic cds, input logic sgl,
                          input logic [7:0] row, input logic [7:0] col);
        @(negedge clk);
        cfg_num_frames = 8'(n); cfg_integ_cycles = 16'(ig); cfg_gap_cycles = 8'(gp);
        cfg_cds = cds; cfg_single = sgl; cfg_row_addr = row; cfg_col_addr = col;
        exp_cds = cds; exp_single = sgl; exp_row = row; exp_col = col;
        clear_stats();
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        cfg_num_frames = 8'($urandom); cfg_integ_cycles = 16'($urandom_range(0, 200));
        cfg_gap_cycles = 8'($urandom); cfg_cds = ~cds; cfg_single = ~sgl;
        cfg_row_addr = ~row; cfg_col_addr = ~col;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_checks++;
        if ({smp_enable, smp_pixel_disable, smp_cds, smp_single_en, busy, frame_done, seq_done, err_timeout} !== 8'h00) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000000",
                {smp_enable, smp_pixel_disable, smp_cds, smp_single_en, busy, frame_done, seq_done, err_timeout});
        end
        n_checks++;
        if ({smp_row_addr, smp_col_addr, frame_idx} !== 24'h0) begin
            n_fail++; $display("FAIL reset_buses: got row=%0d col=%0d idx=%0d want 0", smp_row_addr, smp_col_addr, frame_idx);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_sequences();
        for (int s = 0; s < 9; s++) begin
            int n, ig, gp, i_exp, g_exp, bad, k;
            logic cds, sgl;
            logic [7:0] row, col;
            row = 8'($urandom); col = 8'($urandom);
            case (s)
                0: begin n = 1; ig = 10; gp = 3; cds = 0; sgl = 1; sm_len = 112; end
                1: begin n = 3; ig = 20; gp = 5; cds = 1; sgl = 0; sm_len = 224; end
                2: begin n = 3; ig = 0;  gp = 0; cds = 0; sgl = 0; sm_len = 6;   end
                3: begin n = 2; ig = 1;  gp = 1; cds = 1; sgl = 1; sm_len = 1;   end
                default: begin
                    n = $urandom_range(1, 4); ig = $urandom_range(0, 25); gp = $urandom_range(0, 7);
                    cds = 1'($urandom); sgl = 1'($urandom); sm_len = $urandom_range(1, 40);
                end
            endcase
            i_exp = (ig < 1) ? 1 : ig;
            g_exp = (gp < 2) ? 2 : gp;
            launch(n, ig, gp, cds, sgl, row, col);
            k = 0;
            while (sd_q.size() == 0 && k < 4000) begin @(negedge clk); k++; end
            repeat (3) @(negedge clk);
            n_checks++;
            if (sd_q.size() != 1) begin
                n_fail++; $display("FAIL seq%0d_seq_done_count: got %0d want 1", s, sd_q.size());
            end
            n_checks++;
            if (fd_q.size() != n) begin
                n_fail++; $display("FAIL seq%0d_frame_done_count: got %0d want %0d", s, fd_q.size(), n);
            end
            bad = 0;
            foreach (fd_idx[i]) if (fd_idx[i] != i) bad++;
            foreach (pd_q[i]) if (pd_q[i] != 4) bad++;
            foreach (integ_q[i]) if (integ_q[i] != i_exp) bad++;
            foreach (gap_q[i]) if (gap_q[i] != g_exp) bad++;
            n_checks++;
            if (bad != 0 || pd_q.size() != n || integ_q.size() != n || gap_q.size() != n - 1) begin
                n_fail++; $display("FAIL seq%0d_phase_lengths: %0d bad, sizes pd=%0d integ=%0d gap=%0d want %0d/%0d/%0d (rst=4 integ=%0d gap=%0d)",
                    s, bad, pd_q.size(), integ_q.size(), gap_q.size(), n, n, n - 1, i_exp, g_exp);
            end
            n_checks++;
            if (sd_q.size() == 1 && fd_q.size() > 0 && (sd_q[0] - fd_q[$] != g_exp || gap_last != g_exp)) begin
                n_fail++; $display("FAIL seq%0d_seq_done_delay: got %0d (gap %0d) want %0d", s, sd_q[0] - fd_q[$], gap_last, g_exp);
            end
            n_checks++;
            if (addr_err != 0 || idle_err != 0) begin
                n_fail++; $display("FAIL seq%0d_latched_outputs: got %0d busy / %0d idle mismatches want 0", s, addr_err, idle_err);
            end
            n_checks++;
            if (busy !== 1'b0 || frame_idx !== 8'(n - 1)) begin
                n_fail++; $display("FAIL seq%0d_end_state: got busy=%b idx=%0d want busy=0 idx=%0d", s, busy, frame_idx, n - 1);
            end
        end
    endtask

    task automatic test_abort();
        int k, nfd;
        sm_len = 224;
        launch(3, 5, 3, 1'b1, 1'b0, 8'd5, 8'd6);
        k = 0;
        while (!(frame_idx == 8'd1 && smp_enable) && k < 3000) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        nfd = fd_q.size();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || smp_enable !== 1'b0 || nfd != 1) begin
            n_fail++; $display("FAIL abort_immediate: got busy=%b en=%b frames=%0d want 0/0/1", busy, smp_enable, nfd);
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (fd_q.size() != nfd || sd_q.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_pulses: got fd=%0d sd=%0d busy=%b want fd=%0d sd=0 busy=0", fd_q.size(), sd_q.size(), busy, nfd);
        end
        sm_len = 10;
        launch(1, 2, 2, 1'b0, 1'b0, 8'd1, 8'd2);
        n_checks++;
        if (frame_idx !== 8'd0) begin
            n_fail++; $display("FAIL abort_restart_idx: got %0d want 0", frame_idx);
        end
        k = 0;
        while (sd_q.size() == 0 && k < 500) begin @(negedge clk); k++; end
        n_checks++;
        if (sd_q.size() != 1 || fd_q.size() != 1) begin
            n_fail++; $display("FAIL abort_restart_run: got fd=%0d sd=%0d want 1/1", fd_q.size(), sd_q.size());
        end
    endtask

    task automatic test_start_abort_collision();
        @(negedge clk);
        start_req = 1'b1; abort = 1'b1;
        @(negedge clk);
        start_req = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || smp_pixel_disable !== 1'b0) begin
            n_fail++; $display("FAIL start_abort_same_cycle: got busy=%b pd=%b want 0/0", busy, smp_pixel_disable);
        end
    endtask

    task automatic test_continuous_wrap();
        int k, bad;
        sm_len = 2;
        launch(0, 0, 0, 1'b0, 1'b1, 8'd3, 8'd9);
        k = 0;
        while (fd_q.size() < 258 && k < 12000) begin @(negedge clk); k++; end
        n_checks++;
        if (fd_q.size() < 258) begin
            n_fail++; $display("FAIL continuous_progress: got %0d frames want >=258", fd_q.size());
        end
        bad = 0;
        foreach (fd_idx[i]) if (fd_idx[i] != i % 256) bad++;
        n_checks++;
        if (bad != 0 || (fd_idx.size() > 256 && fd_idx[256] != 0)) begin
            n_fail++; $display("FAIL continuous_frame_idx_wrap: got %0d bad indices want 0", bad);
        end
        bad = 0;
        foreach (gap_q[i]) if (gap_q[i] != 2) bad++;
        foreach (integ_q[i]) if (integ_q[i] != 1) bad++;
        n_checks++;
        if (bad != 0 || sd_q.size() != 0 || addr_err != 0) begin
            n_fail++; $display("FAIL continuous_timing_addr: got %0d bad phases, %0d seq_done, %0d addr errors want 0", bad, sd_q.size(), addr_err);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_readout_stall();
        int k;
        sm_len = 0;
        launch(1, 3, 2, 1'b0, 1'b0, 8'd0, 8'd0);
        k = 0;
        while (!smp_enable && k < 100) begin @(negedge clk); k++; end
`ifdef FRAME_SEQ_TIMEOUT_EN
        k = 0;
        while (smp_enable && k < 1200) begin @(negedge clk); k++; end
        n_checks++;
        if (k != 1024 || err_timeout !== 1'b1 || busy !== 1'b0 || fd_q.size() != 0) begin
            n_fail++; $display("FAIL timeout_fire: got en_cycles=%0d err=%b busy=%b fd=%0d want 1024/1/0/0", k, err_timeout, busy, fd_q.size());
        end
        launch(1, 3, 2, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_clear_on_start: got %b want 0", err_timeout);
        end
`else
        repeat (1100) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || smp_enable !== 1'b1 || err_timeout !== 1'b0 || fd_q.size() != 0) begin
            n_fail++; $display("FAIL readout_waits: got busy=%b en=%b err=%b fd=%0d want 1/1/0/0", busy, smp_enable, err_timeout, fd_q.size());
        end
`endif
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        sm_len = 10;
    endtask

    task automatic test_reset_mid();
        int k;
        sm_len = 10;
        launch(2, 4, 2, 1'b1, 1'b1, 8'd7, 8'd8);
        k = 0;
        while (!smp_pixel_disable && k < 50) begin @(negedge clk); k++; end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || smp_pixel_disable !== 1'b0 || smp_cds !== 1'b0 || smp_row_addr !== 8'd0) begin
            n_fail++; $display("FAIL reset_async_mid: got busy=%b pd=%b cds=%b row=%0d want all 0", busy, smp_pixel_disable, smp_cds, smp_row_addr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_stays_idle: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        clear_stats();
        exp_cds = 1'b0; exp_single = 1'b0; exp_row = '0; exp_col = '0;
        test_reset();
        test_frame_sequences();
        test_abort();
        test_start_abort_collision();
        test_continuous_wrap();
        test_readout_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
